obj_list_writer: RTL and testbench
==================================

# obj_list_writer

Command-driven, double-buffered writer for the object list consumed by `basic_graph`. A sequencer issues append, overwrite, clear and commit commands over a valid/ready handshake; these edit a private shadow list. The shadow list is copied to the displayed (front) list only on a frame-boundary pulse. This gives the renderer a list that never tears mid-frame. It replaces the reset-time hard-coded list in `painter` as the producer of `obj_arr_packed` / `arr_len`.

## Interface
- OBJ_WIDTH, 66, object record width: [65:62] type, [61:52] x, [51:42] y, [41:32] width, [31:22] height, [21:12] radius, [11:0] colour
- MAX_LEN, 16, list capacity
- LEN_BITS, 6, width of length and index fields
- clk  in  1  system clock; one clock domain, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_op  in  2  0 APPEND, 1 WRITE, 2 CLEAR, 3 COMMIT
- cmd_idx  in  LEN_BITS  target entry for WRITE
- cmd_obj  in  OBJ_WIDTH  object record for APPEND and WRITE
- frame_sync  in  1  one-cycle pulse at the start of vertical blanking, synchronous to clk
- obj_arr_packed  out  OBJ_WIDTH*MAX_LEN  front list; entry i occupies bits [(i+1)*OBJ_WIDTH-1 : i*OBJ_WIDTH]
- arr_len  out  LEN_BITS  front list length
- cmd_err  out  1  one-cycle pulse when an accepted command is rejected
- commit_done  out  1  one-cycle pulse on the cycle after the front list updates

## Operation
- Storage: shadow[0..MAX_LEN-1] plus shadow_len; front[0..MAX_LEN-1] plus front_len.
- Invariant: every entry at index ≥ len has type NONE (0). The renderer stops at the first NONE entry.
- FSM states: IDLE, CLEAR, WAIT_SYNC. cmd_ready = (state == IDLE).
- APPEND:
  - If shadow_len < MAX_LEN and the object type ≠ NONE: shadow[shadow_len] ← cmd_obj, shadow_len += 1.
  - Otherwise: no change, cmd_err pulses.
- WRITE:
  - If cmd_idx < shadow_len and the object type ≠ NONE: shadow[cmd_idx] ← cmd_obj.
  - Otherwise: no change, cmd_err pulses.
- CLEAR:
  - shadow_len ← 0 and go to CLEAR.
  - In CLEAR, write all-zero to one shadow entry per cycle, indices 0..MAX_LEN-1.
  - Return to IDLE after the last write.
- COMMIT: go to WAIT_SYNC.
  - On the first frame_sync pulse seen while in WAIT_SYNC: front ← shadow, front_len ← shadow_len, state ← IDLE.
  - The shadow list is retained, so incremental edits after a commit are allowed.
- frame_sync is ignored in IDLE and CLEAR.
- Types 4–15 are accepted unchanged. The renderer treats them as terminators; this block does not check them.

## Timing
- Reset values:
  - front and shadow all-zero, so obj_arr_packed = 0.
  - arr_len = 0, shadow_len = 0.
  - state IDLE, so cmd_ready = 1 on the first cycle after reset.
  - cmd_err = 0, commit_done = 0.
- Reset mid-CLEAR or mid-WAIT_SYNC: returns to the full reset state; any pending commit is discarded.
- APPEND / WRITE:
  - The shadow update is visible on the edge after acceptance.
  - cmd_err is asserted in the cycle after acceptance.
  - Back-to-back acceptance every cycle is supported.
- CLEAR: cmd_ready is low for exactly MAX_LEN cycles after acceptance.
- COMMIT:
  - frame_sync in the acceptance cycle itself does not count.
  - Earliest swap is on the edge at which frame_sync is sampled, one cycle after acceptance.
  - obj_arr_packed and arr_len change atomically on that edge.
  - commit_done pulses in the following cycle, together with cmd_ready returning high.
- Outputs are driven directly from registers; nothing on the output path is combinational.

## Structure
- Shared package `graph_defs`:
  - type enums: NONE 0, RECTANGLE 1, CIRCLE 2, ROUNDRECT 3
  - field bit positions (TYPE/X/Y/WIDTH/HEIGHT/RADIUS/COLOR, left and right bounds)
  - colour constants
  - op codes
  - `basic_graph` uses the same package.
- No sub-module. The block is a single FSM plus two register arrays with a parallel copy path.

## Test plan
- Reset, then APPEND {RECT,100,100,50,20,0,GREEN} and {CIRCLE,200,200,0,0,30,RED}, then COMMIT, then frame_sync five cycles later:
  - arr_len = 2, entry0 = rect, entry1 = circle, entry2 type = 0.
  - commit_done pulses exactly once.
- Edit without commit: APPEND 3 objects, no COMMIT, repeated frame_sync → obj_arr_packed stays 0 and arr_len stays 0.
- Overflow: 16 APPENDs succeed; the 17th pulses cmd_err and arr_len stays 16 after commit. WRITE with idx = 16 also pulses cmd_err.
- Bad WRITE: WRITE idx 3 with shadow_len 2 → cmd_err; WRITE of a NONE-typed object to idx 0 → cmd_err; shadow unchanged, verified after commit.
- CLEAR timing: CLEAR with a full list → cmd_ready low for 16 cycles; after COMMIT and frame_sync, arr_len = 0 and all types are 0.
- Sync edge cases:
  - frame_sync in the same cycle as COMMIT acceptance → no swap; the swap occurs on the next pulse.
  - rst while in WAIT_SYNC → the front list is all-zero and the next frame_sync does nothing.

Source files
------------

// File: rtl/graph_defs.sv
// Shared object-list definitions: record layout, object types, colours,
// list geometry and the command op codes used by the list writer.
package graph_defs;

  localparam int OBJ_WIDTH = 66;
  localparam int MAX_LEN   = 16;
  localparam int LEN_BITS  = 6;
  localparam int IDX_BITS  = $clog2(MAX_LEN);

  // Object types; anything at or above 4 is treated as a terminator by the renderer
  typedef enum logic [3:0] {
    OBJ_NONE      = 4'd0,
    OBJ_RECTANGLE = 4'd1,
    OBJ_CIRCLE    = 4'd2,
    OBJ_ROUNDRECT = 4'd3
  } obj_type_e;

  // Field bounds inside one object record
  localparam int TYPE_L   = 65;
  localparam int TYPE_R   = 62;
  localparam int X_L      = 61;
  localparam int X_R      = 52;
  localparam int Y_L      = 51;
  localparam int Y_R      = 42;
  localparam int WIDTH_L  = 41;
  localparam int WIDTH_R  = 32;
  localparam int HEIGHT_L = 31;
  localparam int HEIGHT_R = 22;
  localparam int RADIUS_L = 21;
  localparam int RADIUS_R = 12;
  localparam int COLOR_L  = 11;
  localparam int COLOR_R  = 0;

  // Common 12-bit RGB colours
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;

  // Sequencer command op codes
  typedef enum logic [1:0] {
    OP_APPEND = 2'd0,
    OP_WRITE  = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_COMMIT = 2'd3
  } op_e;

  // Writer control states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_WAIT_SYNC = 2'd2
  } state_e;

  // Assemble one object record from its fields
  function automatic logic [OBJ_WIDTH-1:0] make_obj(
    input logic [3:0]  obj_type,
    input logic [9:0]  x,
    input logic [9:0]  y,
    input logic [9:0]  width,
    input logic [9:0]  height,
    input logic [9:0]  radius,
    input logic [11:0] color
  );
    return {obj_type, x, y, width, height, radius, color};
  endfunction

endpackage

// File: rtl/obj_list_writer.sv
// Double-buffered object list writer: commands edit a shadow list which is
// copied to the displayed front list only at a frame boundary.
module obj_list_writer
  import graph_defs::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [LEN_BITS-1:0]           cmd_idx,
  input  logic [OBJ_WIDTH-1:0]          cmd_obj,
  input  logic                          frame_sync,
  output logic [OBJ_WIDTH*MAX_LEN-1:0]  obj_arr_packed,
  output logic [LEN_BITS-1:0]           arr_len,
  output logic                          cmd_err,
  output logic                          commit_done
);

  localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);
  localparam logic [IDX_BITS-1:0] CLR_LAST  = IDX_BITS'(MAX_LEN - 1);

  state_e                 state_q, state_d;
  logic [OBJ_WIDTH-1:0]   shadow_q [MAX_LEN];
  logic [OBJ_WIDTH-1:0]   shadow_d [MAX_LEN];
  logic [OBJ_WIDTH-1:0]   front_q  [MAX_LEN];
  logic [OBJ_WIDTH-1:0]   front_d  [MAX_LEN];
  logic [LEN_BITS-1:0]    shadow_len_q, shadow_len_d;
  logic [LEN_BITS-1:0]    front_len_q, front_len_d;
  logic [IDX_BITS-1:0]    clr_idx_q, clr_idx_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   commit_done_q, commit_done_d;
  logic                   obj_is_none;

  assign obj_is_none = (cmd_obj[TYPE_L:TYPE_R] == 4'(OBJ_NONE));

  // Next-state logic: command decode, one-entry-per-cycle clear, sync-gated swap
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    front_d       = front_q;
    shadow_len_d  = shadow_len_q;
    front_len_d   = front_len_q;
    clr_idx_d     = clr_idx_q;
    cmd_err_d     = 1'b0;
    commit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_APPEND: begin
              if ((shadow_len_q < MAX_LEN_L) && !obj_is_none) begin
                shadow_d[shadow_len_q[IDX_BITS-1:0]] = cmd_obj;
                shadow_len_d = shadow_len_q + LEN_BITS'(1);
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            OP_WRITE: begin
              if ((cmd_idx < shadow_len_q) && !obj_is_none) begin
                shadow_d[cmd_idx[IDX_BITS-1:0]] = cmd_obj;
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              shadow_len_d = '0;
              clr_idx_d    = '0;
              state_d      = ST_CLEAR;
            end
            default: begin
              state_d = ST_WAIT_SYNC;
            end
          endcase
        end
      end
      ST_CLEAR: begin
        shadow_d[clr_idx_q] = '0;
        if (clr_idx_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IDX_BITS'(1);
        end
      end
      ST_WAIT_SYNC: begin
        if (frame_sync) begin
          front_d       = shadow_q;
          front_len_d   = shadow_len_q;
          commit_done_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and list registers with synchronous reset back to an empty list
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shadow_len_q  <= '0;
      front_len_q   <= '0;
      clr_idx_q     <= '0;
      cmd_ready_q   <= 1'b1;
      cmd_err_q     <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= '0;
        front_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      shadow_len_q  <= shadow_len_d;
      front_len_q   <= front_len_d;
      clr_idx_q     <= clr_idx_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_err_q     <= cmd_err_d;
      commit_done_q <= commit_done_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= shadow_d[i];
        front_q[i]  <= front_d[i];
      end
    end
  end

  // Flatten the front register array onto the packed output bus
  always_comb begin
    obj_arr_packed = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      obj_arr_packed[i*OBJ_WIDTH +: OBJ_WIDTH] = front_q[i];
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign arr_len     = front_len_q;
  assign cmd_err     = cmd_err_q;
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_obj_list_writer.sv
// Directed self-checking bench for the double-buffered object list writer.
module tb_obj_list_writer;

  localparam int OW = 66;
  localparam int ML = 16;
  localparam int LB = 6;

  localparam logic [1:0] OPC_APPEND = 2'd0;
  localparam logic [1:0] OPC_WRITE  = 2'd1;
  localparam logic [1:0] OPC_CLEAR  = 2'd2;
  localparam logic [1:0] OPC_COMMIT = 2'd3;

  localparam logic [OW-1:0] RECT_OBJ   = {4'd1, 10'd100, 10'd100, 10'd50, 10'd20, 10'd0, 12'h0F0};
  localparam logic [OW-1:0] CIRCLE_OBJ = {4'd2, 10'd200, 10'd200, 10'd0, 10'd0, 10'd30, 12'hF00};
  localparam logic [OW-1:0] RRECT_OBJ  = {4'd3, 10'd10, 10'd20, 10'd30, 10'd40, 10'd5, 12'h00F};
  localparam logic [OW-1:0] NONE_OBJ   = {4'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 12'h123};

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LB-1:0]     cmd_idx;
  logic [OW-1:0]     cmd_obj;
  logic              frame_sync;
  logic [OW*ML-1:0]  obj_arr_packed;
  logic [LB-1:0]     arr_len;
  logic              cmd_err;
  logic              commit_done;

  int checkCount = 0;
  int errorCount = 0;
  int doneCount  = 0;

  obj_list_writer dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_idx        (cmd_idx),
    .cmd_obj        (cmd_obj),
    .frame_sync     (frame_sync),
    .obj_arr_packed (obj_arr_packed),
    .arr_len        (arr_len),
    .cmd_err        (cmd_err),
    .commit_done    (commit_done)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every cycle in which commit_done is high
  always @(negedge clk) begin
    if (commit_done) doneCount++;
  end

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [OW-1:0] entryOf(input int i);
    return obj_arr_packed[i*OW +: OW];
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycles(2);
    rst = 1'b0;
  endtask

  // Issue one command once ready, return cmd_err seen in the following cycle
  task automatic applyStimulus(input logic [1:0] op, input logic [LB-1:0] idx,
                               input logic [OW-1:0] obj, output logic err);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      stepCycles(1);
      n++;
    end
    if (n >= 100) checkOutput("ready_timeout", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_obj   = obj;
    stepCycles(1);
    cmd_valid = 1'b0;
    err       = cmd_err;
  endtask

  task automatic pulseSync();
    frame_sync = 1'b1;
    stepCycles(1);
    frame_sync = 1'b0;
  endtask

  initial begin
    logic err;
    int   okErrs;
    int   lowCycles;
    logic [OW-1:0] obj;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_obj = '0; frame_sync = 1'b0;
    @(posedge clk); #1;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_packed_zero", 128'(|obj_arr_packed), 128'd0);
    checkOutput("rst_arr_len", 128'(arr_len), 128'd0);
    checkOutput("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    checkOutput("rst_cmd_err", 128'(cmd_err), 128'd0);
    checkOutput("rst_commit_done", 128'(commit_done), 128'd0);

    $display("[TB] basic append and commit");
    applyStimulus(OPC_APPEND, '0, RECT_OBJ, err);
    checkOutput("app_rect_err", 128'(err), 128'd0);
    applyStimulus(OPC_APPEND, '0, CIRCLE_OBJ, err);
    checkOutput("app_circle_err", 128'(err), 128'd0);
    applyStimulus(OPC_COMMIT, '0, '0, err);
    checkOutput("commit_ready_low", 128'(cmd_ready), 128'd0);
    stepCycles(4);
    checkOutput("pre_sync_len", 128'(arr_len), 128'd0);
    pulseSync();
    checkOutput("swap_len", 128'(arr_len), 128'd2);
    checkOutput("swap_entry0", 128'(entryOf(0)), 128'(RECT_OBJ));
    checkOutput("swap_entry1", 128'(entryOf(1)), 128'(CIRCLE_OBJ));
    checkOutput("swap_entry2_type", 128'(entryOf(2)[65:62]), 128'd0);
    checkOutput("swap_commit_done", 128'(commit_done), 128'd1);
    checkOutput("swap_ready", 128'(cmd_ready), 128'd1);
    stepCycles(3);
    checkOutput("commit_done_once", 128'(doneCount), 128'd1);

    $display("[TB] edits without commit");
    doReset();
    applyStimulus(OPC_APPEND, '0, RECT_OBJ, err);
    applyStimulus(OPC_APPEND, '0, CIRCLE_OBJ, err);
    applyStimulus(OPC_APPEND, '0, RRECT_OBJ, err);
    for (int i = 0; i < 3; i++) begin
      pulseSync();
      stepCycles(1);
    end
    checkOutput("nocommit_len", 128'(arr_len), 128'd0);
    checkOutput("nocommit_packed", 128'(|obj_arr_packed), 128'd0);

    $display("[TB] overflow");
    doReset();
    okErrs = 0;
    for (int i = 0; i < 16; i++) begin
      obj = {4'd1, 10'(i + 1), 10'd5, 10'd6, 10'd7, 10'd0, 12'hABC};
      applyStimulus(OPC_APPEND, '0, obj, err);
      if (err) okErrs++;
    end
    checkOutput("fill_no_err", 128'(okErrs), 128'd0);
    applyStimulus(OPC_APPEND, '0, RECT_OBJ, err);
    checkOutput("overflow_err", 128'(err), 128'd1);
    stepCycles(1);
    checkOutput("err_one_cycle", 128'(cmd_err), 128'd0);
    applyStimulus(OPC_WRITE, 6'd16, RECT_OBJ, err);
    checkOutput("write16_err", 128'(err), 128'd1);
    applyStimulus(OPC_COMMIT, '0, '0, err);
    pulseSync();
    checkOutput("full_len", 128'(arr_len), 128'd16);
    checkOutput("full_entry15", 128'(entryOf(15)), 128'({4'd1, 10'd16, 10'd5, 10'd6, 10'd7, 10'd0, 12'hABC}));

    $display("[TB] CLEAR timing on full list");
    applyStimulus(OPC_CLEAR, '0, '0, err);
    lowCycles = 0;
    while (!cmd_ready && lowCycles < 50) begin
      lowCycles++;
      stepCycles(1);
    end
    checkOutput("clear_busy_cycles", 128'(lowCycles), 128'd16);
    applyStimulus(OPC_COMMIT, '0, '0, err);
    pulseSync();
    checkOutput("clear_len", 128'(arr_len), 128'd0);
    checkOutput("clear_packed", 128'(|obj_arr_packed), 128'd0);

    $display("[TB] bad writes");
    doReset();
    applyStimulus(OPC_APPEND, '0, RECT_OBJ, err);
    applyStimulus(OPC_APPEND, '0, CIRCLE_OBJ, err);
    applyStimulus(OPC_WRITE, 6'd3, RRECT_OBJ, err);
    checkOutput("write_idx3_err", 128'(err), 128'd1);
    applyStimulus(OPC_WRITE, 6'd0, NONE_OBJ, err);
    checkOutput("write_none_err", 128'(err), 128'd1);
    applyStimulus(OPC_APPEND, '0, NONE_OBJ, err);
    checkOutput("append_none_err", 128'(err), 128'd1);
    applyStimulus(OPC_WRITE, 6'd1, RRECT_OBJ, err);
    checkOutput("write_ok_err", 128'(err), 128'd0);
    applyStimulus(OPC_COMMIT, '0, '0, err);
    pulseSync();
    checkOutput("badw_len", 128'(arr_len), 128'd2);
    checkOutput("badw_entry0", 128'(entryOf(0)), 128'(RECT_OBJ));
    checkOutput("badw_entry1", 128'(entryOf(1)), 128'(RRECT_OBJ));
    checkOutput("badw_entry3", 128'(entryOf(3)), 128'd0);

    $display("[TB] frame_sync during COMMIT acceptance");
    doReset();
    applyStimulus(OPC_APPEND, '0, CIRCLE_OBJ, err);
    cmd_valid = 1'b1; cmd_op = OPC_COMMIT; frame_sync = 1'b1;
    stepCycles(1);
    cmd_valid = 1'b0; frame_sync = 1'b0;
    checkOutput("same_cycle_no_swap", 128'(arr_len), 128'd0);
    stepCycles(2);
    checkOutput("same_cycle_still_wait", 128'(cmd_ready), 128'd0);
    pulseSync();
    checkOutput("next_pulse_swap_len", 128'(arr_len), 128'd1);
    checkOutput("next_pulse_entry0", 128'(entryOf(0)), 128'(CIRCLE_OBJ));

    $display("[TB] reset during WAIT_SYNC");
    applyStimulus(OPC_APPEND, '0, RECT_OBJ, err);
    applyStimulus(OPC_COMMIT, '0, '0, err);
    doReset();
    checkOutput("rst_wait_len", 128'(arr_len), 128'd0);
    checkOutput("rst_wait_packed", 128'(|obj_arr_packed), 128'd0);
    checkOutput("rst_wait_ready", 128'(cmd_ready), 128'd1);
    pulseSync();
    checkOutput("rst_wait_sync_len", 128'(arr_len), 128'd0);
    checkOutput("rst_wait_sync_done", 128'(commit_done), 128'd0);

    stepCycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
